isa_host_master: RTL

- ISA bus initiator that generates IOR/IOW/MEMR/MEMW cycles toward the card's ISA target (CRTC, control, color and status registers, and the B8000 framebuffer window).
- Takes one request at a time from a valid/ready command port and returns a one-cycle response pulse with read data.
- Honours bus_rdy wait states and bounds them with a timeout.
- Used as the bring-up/self-test host and as the bus driver in the card-level bench.

---
 rtl/isa_pkg.sv | 38 +++
 rtl/isa_sync2.sv | 21 ++
 rtl/isa_host_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the ISA host master: op codes, FSM encodings and CGA register addresses.
package isa_pkg;

    typedef enum logic [1:0] {
        OP_IOR  = 2'd0,
        OP_IOW  = 2'd1,
        OP_MEMR = 2'd2,
        OP_MEMW = 2'd3
    } isa_op_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [19:0] CGA_CRTC_INDEX = 20'h003D4;
    localparam logic [19:0] CGA_CRTC_DATA  = 20'h003D5;
    localparam logic [19:0] CGA_MODE_CTRL  = 20'h003D8;
    localparam logic [19:0] CGA_COLOR_SEL  = 20'h003D9;
    localparam logic [19:0] CGA_STATUS     = 20'h003DA;
    localparam logic [19:0] CGA_FB_BASE    = 20'hB8000;

    // Odd op codes are the write cycles.
    function automatic logic op_is_write(input logic [1:0] op);
        return op[0];
    endfunction

    // Strobe vector {memw, memr, iow, ior} with only the op's strobe low.
    function automatic logic [3:0] strobe_for(input logic [1:0] op);
        logic [3:0] s;
        s = 4'hF;
        s[op] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle (ready) bus is assumed out of reset.
module isa_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/isa_host_master.sv
// ISA bus initiator: runs one IOR/IOW/MEMR/MEMW cycle per accepted command with
// setup/command/hold timing, bus_rdy wait states bounded by a timeout, and a one-clock response.
module isa_host_master
    import isa_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int CMD_CYCLES   = 6,
    parameter int HOLD_CYCLES  = 2,
    parameter int RDY_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    input  logic        bus_rdy
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES);
    localparam logic [7:0] CMD_LAST   = 8'(CMD_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(RDY_TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  wait_cnt;
    logic [1:0]  op_q;
    logic [19:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        timeout_q;
    logic [3:0]  strobe_l;
    logic        rdy_s;

    isa_sync2 u_rdy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus_rdy),
        .q     (rdy_s)
    );

    assign bus_ior_l  = strobe_l[0];
    assign bus_iow_l  = strobe_l[1];
    assign bus_memr_l = strobe_l[2];
    assign bus_memw_l = strobe_l[3];

    // SETUP spends its first edge driving address/data and its final edge dropping the strobe,
    // which is where the extra clock in the accept-to-response latency comes from.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            wait_cnt    <= 8'd0;
            op_q        <= OP_IOR;
            addr_q      <= 20'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            timeout_q   <= 1'b0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_timeout <= 1'b0;
            bus_a       <= 20'd0;
            bus_aen     <= 1'b1;
            bus_d_out   <= 8'd0;
            bus_d_oe    <= 1'b0;
            strobe_l    <= 4'hF;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rdata_q   <= 8'd0;
                        timeout_q <= 1'b0;
                        cnt       <= 8'd0;
                        req_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd0) begin
                        bus_a   <= addr_q;
                        bus_aen <= 1'b0;
                        if (op_is_write(op_q)) begin
                            bus_d_out <= wdata_q;
                            bus_d_oe  <= 1'b1;
                        end
                    end
                    if (cnt == SETUP_LAST) begin
                        strobe_l <= strobe_for(op_q);
                        cnt      <= 8'd0;
                        state    <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cnt == CMD_LAST) begin
                        cnt <= 8'd0;
                        if (rdy_s) begin
                            rdata_q  <= op_is_write(op_q) ? 8'd0 : bus_d_in;
                            strobe_l <= 4'hF;
                            state    <= ST_HOLD;
                        end else begin
                            wait_cnt <= 8'd0;
                            state    <= ST_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    // A ready target wins over a timeout that expires on the same clock.
                    if (rdy_s || wait_cnt == WAIT_LAST) begin
                        rdata_q   <= op_is_write(op_q) ? 8'd0 : bus_d_in;
                        timeout_q <= !rdy_s;
                        strobe_l  <= 4'hF;
                        state     <= ST_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        bus_d_oe    <= 1'b0;
                        bus_aen     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= rdata_q;
                        rsp_timeout <= timeout_q;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
